// File: rtl/cordic_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | cordic_channel_scheduler: round-robin shares one CORDIC kernel among     |
// | NUM_CH I/Q streams and tags results with their source channel.           |
// | Optional: CORDIC_SCHED_STATS_EN adds per-channel issue counters.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module cordic_channel_scheduler #(
  parameter int NUM_CH         = 4,
  parameter int DATA_SIZE      = 16,
  parameter int FULL_SIZE      = 20,
  parameter int CORDIC_LATENCY = 18,
  localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic [NUM_CH-1:0]             s_valid,
  output logic [NUM_CH-1:0]             s_ready,
  input  logic [NUM_CH*DATA_SIZE-1:0]   s_data_i,
  input  logic [NUM_CH*DATA_SIZE-1:0]   s_data_q,
  output logic [FULL_SIZE-1:0]          cordic_data_i,
  output logic [FULL_SIZE-1:0]          cordic_data_q,
  output logic                          cordic_enable,
  input  logic [FULL_SIZE-1:0]          cordic_amp,
  input  logic [FULL_SIZE-1:0]          cordic_ph,
  input  logic                          cordic_valid,
  output logic [FULL_SIZE-1:0]          m_amp,
  output logic [FULL_SIZE-1:0]          m_ph,
  output logic [CH_W-1:0]               m_ch,
  output logic                          m_valid,
  output logic                          busy,
`ifdef CORDIC_SCHED_STATS_EN
  output logic [NUM_CH*16-1:0]          issue_cnt,
`endif
  output logic                          tag_err
);

  localparam int              BLANK_W  = $clog2(CORDIC_LATENCY + 1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CH_W:0]   NUM_CH_W = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CH_W-1:0]        ptr_q, ptr_d;
  logic [CH_W-1:0]        gnt_ch;
  logic                   gnt_found;
  logic                   accept;
  logic [CH_W:0]          idx_sum;
  logic [DATA_SIZE-1:0]   sel_i, sel_q;
  logic                   enable_q;
  logic [CH_W-1:0]        issue_ch_q;
  logic [FULL_SIZE-1:0]   data_i_q, data_q_q;
  logic [CORDIC_LATENCY-1:0] tag_v_q;
  logic [CH_W-1:0]        tag_ch_q [CORDIC_LATENCY];
  logic [BLANK_W-1:0]     blank_q;
  logic                   cordic_live;
  logic                   pipe_busy;
  logic                   m_valid_q;
  logic [FULL_SIZE-1:0]   m_amp_q, m_ph_q;
  logic [CH_W-1:0]        m_ch_q;
  logic                   tag_err_q;

  // Rotating priority search: offset k from the pointer, wrapped modulo NUM_CH.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    idx_sum   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_sum = {1'b0, ptr_q} + (CH_W + 1)'(k);
      if (idx_sum >= NUM_CH_W) idx_sum = idx_sum - NUM_CH_W;
      if (!gnt_found && s_valid[idx_sum[CH_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_ch    = idx_sum[CH_W-1:0];
      end
    end
  end

  always_comb begin
    sel_i = '0;
    sel_q = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_ch == CH_W'(k)) begin
        sel_i = s_data_i[k*DATA_SIZE +: DATA_SIZE];
        sel_q = s_data_q[k*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign accept  = (state_q == ST_RUN) && gnt_found;
  assign s_ready = accept ? (NUM_CH'(1) << gnt_ch) : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (accept) ptr_d = (gnt_ch == LAST_CH) ? '0 : gnt_ch + CH_W'(1);
  end

  // The issue register counts as in flight so DRAIN cannot exit before its tag enters the pipe.
  assign pipe_busy = enable_q | (|tag_v_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_RUN;
      ST_RUN:   if (!run) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (run)             state_d = ST_RUN;
        else if (!pipe_busy) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign cordic_live = cordic_valid && (blank_q == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      enable_q   <= 1'b0;
      issue_ch_q <= '0;
      data_i_q   <= '0;
      data_q_q   <= '0;
      tag_v_q    <= '0;
      for (int k = 0; k < CORDIC_LATENCY; k++) tag_ch_q[k] <= '0;
      blank_q    <= BLANK_W'(CORDIC_LATENCY);
      m_valid_q  <= 1'b0;
      m_amp_q    <= '0;
      m_ph_q     <= '0;
      m_ch_q     <= '0;
      tag_err_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      enable_q <= accept;
      if (accept) begin
        issue_ch_q <= gnt_ch;
        data_i_q   <= {{(FULL_SIZE-DATA_SIZE){sel_i[DATA_SIZE-1]}}, sel_i};
        data_q_q   <= {{(FULL_SIZE-DATA_SIZE){sel_q[DATA_SIZE-1]}}, sel_q};
      end
      tag_v_q     <= {tag_v_q[CORDIC_LATENCY-2:0], enable_q};
      tag_ch_q[0] <= issue_ch_q;
      for (int k = 1; k < CORDIC_LATENCY; k++) tag_ch_q[k] <= tag_ch_q[k-1];
      if (blank_q != '0) blank_q <= blank_q - BLANK_W'(1);
      m_valid_q <= cordic_live;
      if (cordic_live) begin
        m_amp_q <= cordic_amp;
        m_ph_q  <= cordic_ph;
        m_ch_q  <= tag_ch_q[CORDIC_LATENCY-1];
      end
      if ((blank_q == '0) && (tag_v_q[CORDIC_LATENCY-1] != cordic_valid)) tag_err_q <= 1'b1;
    end
  end

  assign cordic_enable = enable_q;
  assign cordic_data_i = data_i_q;
  assign cordic_data_q = data_q_q;
  assign m_valid       = m_valid_q;
  assign m_amp         = m_amp_q;
  assign m_ph          = m_ph_q;
  assign m_ch          = m_ch_q;
  assign busy          = (state_q != ST_IDLE);
  assign tag_err       = tag_err_q;

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (accept && (gnt_ch == CH_W'(k)) && (cnt_q[k] != 16'hFFFF)) cnt_q[k] <= cnt_q[k] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt_out
    assign issue_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cordic_channel_scheduler: randomized bench with a queue-based model   |
// | of arbitration, kernel latency, draining and blanking.                   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cordic_channel_scheduler;

  localparam int NCH = 4;
  localparam int LAT = 18;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [3:0]  s_valid = '0;
  logic [3:0]  s_ready;
  logic [63:0] s_data_i = '0;
  logic [63:0] s_data_q = '0;
  logic [19:0] cordic_data_i, cordic_data_q;
  logic        cordic_enable;
  logic [19:0] cordic_amp = '0;
  logic [19:0] cordic_ph = '0;
  logic        cordic_valid = 1'b0;
  logic [19:0] m_amp, m_ph;
  logic [1:0]  m_ch;
  logic        m_valid, busy, tag_err;
`ifdef CORDIC_SCHED_STATS_EN
  logic [63:0] issue_cnt;
`endif

  cordic_channel_scheduler #(
    .NUM_CH(NCH), .DATA_SIZE(16), .FULL_SIZE(20), .CORDIC_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .run(run),
    .s_valid(s_valid), .s_ready(s_ready), .s_data_i(s_data_i), .s_data_q(s_data_q),
    .cordic_data_i(cordic_data_i), .cordic_data_q(cordic_data_q), .cordic_enable(cordic_enable),
    .cordic_amp(cordic_amp), .cordic_ph(cordic_ph), .cordic_valid(cordic_valid),
    .m_amp(m_amp), .m_ph(m_ph), .m_ch(m_ch), .m_valid(m_valid), .busy(busy),
`ifdef CORDIC_SCHED_STATS_EN
    .issue_cnt(issue_cnt),
`endif
    .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int ch; logic [15:0] i; logic [15:0] q; } acc_t;
  typedef struct { int due; logic [19:0] a; logic [19:0] p; } ker_t;

  acc_t aq[$];
  ker_t kq[$];
  int   n_total = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   blank_until = 0;
  int   ptr_m = 0;
  int   st_m = 0;          // 0 idle, 1 run, 2 drain
  bit   exp_err = 1'b0;
  bit   kv_prev = 1'b0;
  bit   acc_prev = 1'b0;
  logic [15:0] prev_i = '0, prev_q = '0;
  bit   hold_data = 1'b0;
  logic [63:0] fix_i = '0, fix_q = '0;
  bit   acc;

  function automatic logic [19:0] sext(input logic [15:0] x);
    return {{4{x[15]}}, x};
  endfunction
  function automatic logic [19:0] kamp(input logic [19:0] x);
    return x ^ 20'h5A5A5;
  endfunction
  function automatic logic [19:0] kph(input logic [19:0] x);
    return x + 20'h00123;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Kernel stand-in: each enable comes back LAT cycles later as a deterministic function.
  task automatic drive_kernel(input bit inj);
    if (cordic_enable === 1'b1) kq.push_back('{cyc + LAT, kamp(cordic_data_i), kph(cordic_data_q)});
    cordic_valid = 1'b0;
    if (kq.size() > 0 && kq[0].due == cyc) begin
      cordic_valid = 1'b1;
      cordic_amp   = kq[0].a;
      cordic_ph    = kq[0].p;
      void'(kq.pop_front());
    end else if (inj) begin
      cordic_valid = 1'b1;
      cordic_amp   = 20'($urandom());
      cordic_ph    = 20'($urandom());
    end
  endtask

  // Entered at a negedge: checks this cycle's registered outputs, drives inputs, advances a cycle.
  task automatic step(input bit run_v, input logic [3:0] sv, input bit inj, output bit acc_o);
    int gch;
    bit tail_now, pipe_busy;
    logic [3:0] want_oh;
    logic [15:0] di, dq;
    check_eq("cordic_enable", cordic_enable, acc_prev);
    if (acc_prev) begin
      check_eq("cordic_data_i", cordic_data_i, sext(prev_i));
      check_eq("cordic_data_q", cordic_data_q, sext(prev_q));
    end
    check_eq("m_valid", m_valid, kv_prev);
    while (aq.size() > 0 && aq[0].due < cyc) begin
      check_eq("result_lost", aq[0].due, cyc);
      void'(aq.pop_front());
    end
    if (aq.size() > 0 && aq[0].due == cyc) begin
      check_eq("m_valid_due", m_valid, 1);
      check_eq("m_ch", m_ch, aq[0].ch);
      check_eq("m_amp", m_amp, kamp(sext(aq[0].i)));
      check_eq("m_ph", m_ph, kph(sext(aq[0].q)));
      void'(aq.pop_front());
    end
    check_eq("tag_err", tag_err, exp_err);
    check_eq("busy", busy, st_m != 0);

    drive_kernel(inj);
    run     = run_v;
    s_valid = sv;
    if (hold_data) begin
      s_data_i = fix_i;
      s_data_q = fix_q;
    end else begin
      s_data_i = {$urandom(), $urandom()};
      s_data_q = {$urandom(), $urandom()};
    end
    #1;

    acc_o = 1'b0;
    gch   = 0;
    if (st_m == 1) begin
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (ptr_m + k) % NCH;
        if (!acc_o && sv[c]) begin
          acc_o = 1'b1;
          gch   = c;
        end
      end
    end
    want_oh = acc_o ? (4'b0001 << gch) : 4'b0000;
    check_eq("s_ready", s_ready, want_oh);

    pipe_busy = acc_prev;
    tail_now  = 1'b0;
    foreach (aq[n]) begin
      if (aq[n].due <= cyc + LAT + 1) pipe_busy = 1'b1;
      if (aq[n].due == cyc + 1) tail_now = 1'b1;
    end
    if (cyc > blank_until && (cordic_valid != tail_now)) exp_err = 1'b1;
    kv_prev = cordic_valid && (cyc > blank_until);

    di = '0;
    dq = '0;
    if (acc_o) begin
      di = s_data_i[gch*16 +: 16];
      dq = s_data_q[gch*16 +: 16];
      aq.push_back('{cyc + LAT + 2, gch, di, dq});
      ptr_m = (gch + 1) % NCH;
    end
    acc_prev = acc_o;
    prev_i   = di;
    prev_q   = dq;

    case (st_m)
      0:       if (run_v) st_m = 1;
      1:       if (!run_v) st_m = 2;
      default: if (run_v) st_m = 1; else if (!pipe_busy) st_m = 0;
    endcase

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    run     = 1'b0;
    s_valid = '0;
    drive_kernel(1'b0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    reset = 1'b1;
    aq.delete();
    ptr_m       = 0;
    st_m        = 0;
    exp_err     = 1'b0;
    kv_prev     = 1'b0;
    acc_prev    = 1'b0;
    blank_until = cyc - 1 + LAT;
    check_eq("rst_cordic_enable", cordic_enable, 0);
    check_eq("rst_cordic_data_i", cordic_data_i, 0);
    check_eq("rst_cordic_data_q", cordic_data_q, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_amp", m_amp, 0);
    check_eq("rst_m_ph", m_ph, 0);
    check_eq("rst_m_ch", m_ch, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_tag_err", tag_err, 0);
    check_eq("rst_s_ready", s_ready, 0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Blanking then misalignment with an empty pipe.
    for (int j = 0; j < 40; j++) step(1'b0, 4'b0000, (j == 2) || (j == 29), acc);
    do_reset();

    // Single sample from channel 2 with extreme values.
    hold_data = 1'b1;
    fix_i = 64'h0000_8000_0000_0000;
    fix_q = 64'h0000_7FFF_0000_0000;
    begin
      bit got;
      got = 1'b0;
      for (int j = 0; j < 8; j++) begin
        step(1'b1, got ? 4'b0000 : 4'b0100, 1'b0, acc);
        if (acc) begin
          got = 1'b1;
          check_eq("single_data_i", cordic_data_i, 20'hF8000);
          check_eq("single_data_q", cordic_data_q, 20'h07FFF);
        end
      end
    end
    hold_data = 1'b0;
    for (int j = 0; j < LAT + 4; j++) step(1'b1, 4'b0000, 1'b0, acc);

    // Fairness with all channels requesting.
    for (int j = 0; j < 40; j++) step(1'b1, 4'b1111, 1'b0, acc);
    for (int j = 0; j < LAT + 4; j++) step(1'b1, 4'b0000, 1'b0, acc);

    // Skip/wrap: land the pointer on 3, then only channels 1 and 3 request.
    step(1'b1, 4'b0100, 1'b0, acc);
    for (int j = 0; j < 6; j++) step(1'b1, 4'b1010, 1'b0, acc);

    // Random traffic with occasional run drops.
    for (int j = 0; j < 400; j++) step($urandom_range(0, 11) != 0, 4'($urandom()), 1'b0, acc);

    // Drain with five samples in flight.
    step(1'b1, 4'b0000, 1'b0, acc);
    step(1'b1, 4'b0000, 1'b0, acc);
    for (int j = 0; j < 5; j++) step(1'b1, 4'b1111, 1'b0, acc);
    for (int j = 0; j < LAT + 8; j++) step(1'b0, 4'b0000, 1'b0, acc);

    // Reset with three samples in flight; stale kernel results must be suppressed.
    step(1'b1, 4'b0000, 1'b0, acc);
    for (int j = 0; j < 3; j++) step(1'b1, 4'b1111, 1'b0, acc);
    do_reset();
    for (int j = 0; j < LAT + 4; j++) step(1'b0, 4'b0000, 1'b0, acc);
    step(1'b1, 4'b0000, 1'b0, acc);
    for (int j = 0; j < 3; j++) step(1'b1, 4'b1111, 1'b0, acc);
    for (int j = 0; j < LAT + 8; j++) step(1'b0, 4'b0000, 1'b0, acc);
    check_eq("leftover_results", aq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cordic_channel_scheduler.md
Name: cordic_channel_scheduler

Overview:
- Time-shares one CORDIC amplitude/phase kernel among NUM_CH independent I/Q sample streams.
- Round-robin arbitration admits at most one sample per cycle. Each accepted sample is sign-extended and issued to the kernel.
- A channel tag rides alongside the fixed kernel latency, so every amplitude/phase result leaves labelled with its source channel.
- Sits between the per-channel front-ends and the CORDIC kernel; a RUN/DRAIN control FSM lets software stop and flush it cleanly.

Parameters:
- NUM_CH, 4, number of requesting channels (2..16).
- DATA_SIZE, 16, input I/Q sample width (two's complement).
- FULL_SIZE, 20, kernel operand/result width; FULL_SIZE > DATA_SIZE.
- CORDIC_LATENCY, 18, cycles from kernel enable to kernel output valid (≥2).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- run  in  1  level; 1 = accept samples, 0 = stop accepting and drain.
- s_valid  in  NUM_CH  per-channel sample valid.
- s_ready  out  NUM_CH  per-channel grant (one-hot or zero).
- s_data_i  in  NUM_CH*DATA_SIZE  packed I samples, channel k at [k*DATA_SIZE +: DATA_SIZE].
- s_data_q  in  NUM_CH*DATA_SIZE  packed Q samples, same packing.
- cordic_data_i  out  FULL_SIZE  sign-extended I to kernel.
- cordic_data_q  out  FULL_SIZE  sign-extended Q to kernel.
- cordic_enable  out  1  kernel input strobe.
- cordic_amp  in  FULL_SIZE  kernel amplitude result.
- cordic_ph  in  FULL_SIZE  kernel phase result.
- cordic_valid  in  1  kernel result strobe.
- m_amp  out  FULL_SIZE  registered amplitude.
- m_ph  out  FULL_SIZE  registered phase.
- m_ch  out  $clog2(NUM_CH)  source channel of m_amp/m_ph.
- m_valid  out  1  result strobe (no backpressure).
- busy  out  1  state != IDLE.
- tag_err  out  1  sticky: kernel result/tag misalignment.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs 0.
  - Tag pipe cleared; round-robin pointer set to channel 0.
  - State IDLE; blanking counter loaded with CORDIC_LATENCY.
- FSM states:
  - IDLE: s_ready=0. Go to RUN when run==1.
  - RUN: arbitration enabled. Go to DRAIN when run==0.
  - DRAIN: s_ready=0. Go to IDLE when the tag pipe holds no valid entry. If run returns to 1 while in DRAIN, go straight back to RUN.
- Arbitration (RUN only):
  - Search s_valid starting at the pointer, wrapping modulo NUM_CH. Grant the first set bit.
  - s_ready is combinational from s_valid and the pointer.
  - Accept = s_valid[k] & s_ready[k].
  - On accept, pointer <= k+1 (wrapping NUM_CH-1 -> 0). With no accept, the pointer holds.
- Issue:
  - A sample accepted in cycle t appears at cycle t+1 with cordic_enable=1.
  - cordic_data_i/q are registered and sign-extended (MSB replicated FULL_SIZE-DATA_SIZE times).
  - Without an accept, cordic_enable=0 and the data registers hold.
- Tag pipe:
  - CORDIC_LATENCY-stage shift register of {valid, ch}.
  - A stage is loaded with {cordic_enable, granted ch} in the same cycle as the issue, so the tail aligns with cordic_valid at t+1+CORDIC_LATENCY.
- Output:
  - At t+2+CORDIC_LATENCY: m_valid=1, m_amp/m_ph = the captured cordic_amp/cordic_ph, m_ch = tail tag ch.
  - Otherwise m_valid=0 and the data outputs hold.
  - Total accept-to-result latency is CORDIC_LATENCY+2.
- Misalignment:
  - If the tail tag valid differs from cordic_valid, set tag_err=1 (sticky until reset).
  - Still emit m_valid on cordic_valid, with m_ch = tail ch.
- Blanking:
  - For CORDIC_LATENCY cycles after reset, cordic_valid is ignored: no m_valid, no tag_err. This tolerates stale kernel output.
  - The counter decrements to 0 and stays there.
- Reset mid-operation: all in-flight tags are discarded; no results are emitted for samples accepted before reset.
- Throughput: one sample per cycle sustained. With N channels continuously valid, each channel is granted exactly once every N cycles.

Optional Feature:
- Macro: CORDIC_SCHED_STATS_EN.
- Defined:
  - Adds output port issue_cnt (NUM_CH*16 bits): per-channel 16-bit saturating counts of accepted samples.
  - Counters are cleared by reset, increment on accept, and hold at 16'hFFFF.
- Undefined: the port and counters are absent; all other behaviour is identical.

Test Plan:
- Single channel: run=1, ch2 sends I=16'h8000, Q=16'h7FFF once -> cordic_data_i=20'hF8000, cordic_data_q=20'h07FFF one cycle after accept; m_valid with m_ch=2 exactly CORDIC_LATENCY+2 cycles after accept.
- Fairness: all 4 s_valid held high for 40 cycles -> grant order 0,1,2,3,0,…, 10 grants each, m_ch sequence identical and delayed by 20 cycles.
- Skip/wrap: pointer at 3, only ch1 and ch3 valid -> ch3 granted, then ch1, then ch3; no idle cycles.
- Drain: 5 samples in flight, drop run -> s_ready=0 next cycle, busy=1 until the 5th m_valid, IDLE the cycle after the tail empties.
- Misalignment/blanking: cordic_valid pulsed at cycle 3 after reset -> no m_valid, tag_err=0; pulse again at cycle 30 with empty pipe -> tag_err=1 and stays 1.
- Reset mid-flight: 3 samples accepted, reset low 1 cycle -> no m_valid for them, pointer=0, all outputs 0.
